// File: rtl/fsm_stream_sequencer_pkg.sv
// Shared types and constants for the serial stream sequencer.
// Contains the controller state enum, core state codes and WIDTH check.
package fsm_stream_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } ctrl_state_t;

    // Core {Qa,Qb} encodings
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ONE  = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/mealy_edge_core.sv
// Two-flop Mealy rising-edge detector on a serial bit stream.
// Ports: CLK, RES (async high), clr (to 00, wins over en), en, I;
// Y (combinational, 1 on first 1 after 0/clear), Qa, Qb (state flops).
module mealy_edge_core
    import fsm_stream_sequencer_pkg::*;
(
    input  logic CLK,
    input  logic RES,
    input  logic clr,
    input  logic en,
    input  logic I,
    output logic Y,
    output logic Qa,
    output logic Qb
);

    logic r_qa;
    logic r_qb;
    logic w_s;
    logic w_qa_nxt;
    logic w_qb_nxt;

    assign w_s      = r_qa | r_qb;
    assign w_qa_nxt = w_s & I;
    assign w_qb_nxt = ~w_s & I;
    assign Y        = w_qb_nxt;
    assign Qa       = r_qa;
    assign Qb       = r_qb;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            {r_qa, r_qb} <= S_IDLE;
        end else if (clr) begin
            {r_qa, r_qb} <= S_IDLE;
        end else if (en) begin
            {r_qa, r_qb} <= {w_qa_nxt, w_qb_nxt};
        end
    end

endmodule

// File: rtl/fsm_stream_sequencer.sv
// Word-to-serial controller around mealy_edge_core: accepts a word, shifts
// it MSB first through the core and returns the collected Y bits.
// Ports: CLK, RES (async high); in_valid/in_ready/in_data/in_keep producer
// side; out_valid/out_ready/out_data consumer side; busy, core_q debug.
module fsm_stream_sequencer
    import fsm_stream_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_keep,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       core_q
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("fsm_stream_sequencer: WIDTH must be 1..32");
    end

    localparam int CW = $clog2(WIDTH + 1);

    ctrl_state_t      r_state;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_clr;
    logic             w_en;
    logic             w_bit;
    logic             w_y;
    logic             w_qa;
    logic             w_qb;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_accept  = (r_state == ST_IDLE) & in_valid;
    assign w_clr     = w_accept & ~in_keep;
    assign w_en      = (r_state == ST_SHIFT);
    assign w_bit     = r_sh[WIDTH-1];
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_res_nxt = (r_res << 1) | WIDTH'(w_y);

    mealy_edge_core u_core (
        .CLK (CLK),
        .RES (RES),
        .clr (w_clr),
        .en  (w_en),
        .I   (w_bit),
        .Y   (w_y),
        .Qa  (w_qa),
        .Qb  (w_qb)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sh    <= in_data;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sh  <= r_sh << 1;
                    r_res <= w_res_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // publish only the finished word so out_data
                        // stays put while the next word shifts
                        r_out   <= w_res_nxt;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SHIFT) | (r_state == ST_DONE);
    assign out_data  = r_out;
    assign core_q    = {w_qa, w_qb};

endmodule

// File: tb/tb_fsm_stream_sequencer.sv
// Self-checking bench for fsm_stream_sequencer (WIDTH=8 and WIDTH=1).
// Table vectors, hand sequences and random words against a bit model.
module tb_fsm_stream_sequencer;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_keep = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;
    logic [1:0] core_q;

    logic       u1_in_valid = 1'b0;
    logic       u1_in_ready;
    logic [0:0] u1_in_data = '0;
    logic       u1_in_keep = 1'b0;
    logic       u1_out_valid;
    logic       u1_out_ready = 1'b1;
    logic [0:0] u1_out_data;
    logic       u1_busy;
    logic [1:0] u1_core_q;

    int checks = 0;
    int failures = 0;
    int m_run = 0;
    int cyc = 0;
    int acc_q[$];

    always #5 CLK = ~CLK;

    fsm_stream_sequencer #(.WIDTH(8)) dut (
        .CLK(CLK), .RES(RES),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .core_q(core_q)
    );

    fsm_stream_sequencer #(.WIDTH(1)) dut1 (
        .CLK(CLK), .RES(RES),
        .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_data(u1_in_data), .in_keep(u1_in_keep),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready),
        .out_data(u1_out_data), .busy(u1_busy), .core_q(u1_core_q)
    );

    always @(posedge CLK) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: Y is 1 for a 1 that follows a 0 or a clear.
    // m_run is the length of the trailing run of 1s seen by the core.
    task automatic model_word(input logic [7:0] d, input logic keep,
                              output logic [7:0] y, output logic [1:0] q);
        if (!keep) m_run = 0;
        for (int i = 7; i >= 0; i--) begin
            y[i] = d[i] && (m_run == 0);
            m_run = d[i] ? m_run + 1 : 0;
        end
        q = (m_run == 0) ? 2'b00 : (m_run == 1) ? 2'b01 : 2'b10;
    endtask

    // Called just after a posedge with the DUT in IDLE.
    task automatic send(input logic [7:0] d, input logic keep,
                        input int hold, output logic [7:0] got,
                        output logic [1:0] gq, output int lat);
        in_data = d;
        in_keep = keep;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_keep = 1'($urandom);
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!out_valid && lat < 50);
        got = out_data;
        gq = core_q;
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge CLK); #1;
            end
            chk("hold_valid", out_valid, 1'b1);
            out_ready = 1'b1;
        end
        @(posedge CLK); #1;
        chk("valid_drop", out_valid, 1'b0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       keep;
        logic [7:0] exp_y;
        logic [1:0] exp_q;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [7:0] got, ey, hold_val;
        logic [1:0] gq, eq;
        int lat;

        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got, ey, hold_val;
        logic [1:0] gq, eq;
        int lat;

        vt[0] = '{8'h6E, 1'b0, 8'h48, 2'b00};
        vt[1] = '{8'h01, 1'b0, 8'h01, 2'b01};
        vt[2] = '{8'h80, 1'b1, 8'h00, 2'b00};
        vt[3] = '{8'h80, 1'b0, 8'h80, 2'b00};
        vt[4] = '{8'hFF, 1'b0, 8'h80, 2'b10};
        vt[5] = '{8'h00, 1'b0, 8'h00, 2'b00};
        vt[6] = '{8'hAA, 1'b0, 8'hAA, 2'b00};
        vt[7] = '{8'h55, 1'b1, 8'h55, 2'b01};
        vt[8] = '{8'h0F, 1'b1, 8'h08, 2'b10};

        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_core_q", core_q, 2'b00);
        #9 RES = 1'b0;
        @(posedge CLK); #1;

        // WIDTH=1 build: result one edge after accept
        u1_in_data = 1'b1;
        u1_in_valid = 1'b1;
        @(posedge CLK); #1;
        u1_in_valid = 1'b0;
        chk("w1_not_yet", u1_out_valid, 1'b0);
        @(posedge CLK); #1;
        chk("w1_valid", u1_out_valid, 1'b1);
        chk("w1_data", u1_out_data, 1'b1);
        @(posedge CLK); #1;
        chk("w1_idle", u1_in_ready, 1'b1);

        // Table vectors
        foreach (vt[i]) begin
            send(vt[i].d, vt[i].keep, 0, got, gq, lat);
            model_word(vt[i].d, vt[i].keep, ey, eq);
            chk($sformatf("tbl%0d_y", i), got, vt[i].exp_y);
            chk($sformatf("tbl%0d_q", i), gq, vt[i].exp_q);
            chk($sformatf("tbl%0d_model", i), ey, vt[i].exp_y);
            chk($sformatf("tbl%0d_lat", i), lat, 8);
        end

        // DONE held with out_ready low; pulsed in_valid ignored
        in_data = 8'h6E;
        in_keep = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        model_word(8'h6E, 1'b0, ey, eq);
        repeat (8) begin
            @(posedge CLK); #1;
        end
        chk("stall_valid", out_valid, 1'b1);
        hold_val = out_data;
        chk("stall_data0", hold_val, ey);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            in_data = 8'hFF;
            @(posedge CLK); #1;
            in_valid = 1'b0;
            chk("stall_valid_k", out_valid, 1'b1);
            chk("stall_data_k", out_data, hold_val);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("stall_release", out_valid, 1'b0);
        @(posedge CLK); #1;
        chk("stall_no_accept", busy, 1'b0);
        chk("stall_data_held", out_data, hold_val);

        // Back-to-back words, in_valid held high
        acc_q.delete();
        in_data = 8'hFF;
        in_keep = 1'b0;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_data = 8'h00;
        model_word(8'hFF, 1'b0, ey, eq);
        repeat (8) begin
            @(posedge CLK); #1;
        end
        chk("b2b_valid0", out_valid, 1'b1);
        chk("b2b_data0", out_data, ey);
        repeat (2) begin
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        model_word(8'h00, 1'b0, ey, eq);
        repeat (8) begin
            @(posedge CLK); #1;
        end
        chk("b2b_valid1", out_valid, 1'b1);
        chk("b2b_data1", out_data, ey);
        @(posedge CLK); #1;
        chk("b2b_count", acc_q.size(), 2);
        if (acc_q.size() == 2)
            chk("b2b_spacing", acc_q[1] - acc_q[0], 10);

        // Asynchronous reset mid-shift
        in_data = 8'hFF;
        in_keep = 1'b0;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        chk("abort_busy", busy, 1'b1);
        #2 RES = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy0", busy, 1'b0);
        chk("abort_out_data", out_data, 8'h00);
        chk("abort_core_q", core_q, 2'b00);
        m_run = 0;
        @(posedge CLK); #1;
        RES = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            chk("abort_no_valid", out_valid, 1'b0);
        end
        send(8'hAA, 1'b0, 0, got, gq, lat);
        model_word(8'hAA, 1'b0, ey, eq);
        chk("abort_next", got, 8'hAA);
        chk("abort_next_model", got, ey);

        // Random words against the model
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       kp;
            int         hd;
            d = 8'($urandom);
            kp = 1'($urandom);
            hd = $urandom_range(0, 3);
            send(d, kp, hd, got, gq, lat);
            model_word(d, kp, ey, eq);
            chk($sformatf("rnd%0d_y_d%02h_k%0d", n, d, kp), got, ey);
            chk($sformatf("rnd%0d_q", n), gq, eq);
            chk($sformatf("rnd%0d_lat", n), lat, 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
